// File: rtl/mlp_layer_sequencer.sv
// Sequences one shared dense engine through the MLP layers for a single frame,
// then runs softmax and holds the result until the consumer takes it.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS  = 4,
  parameter int LAYER_W     = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int TMR_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               in_capture,
  output logic               eng_start,
  output logic [LAYER_W-1:0] eng_layer,
  output logic               eng_src_sel,
  output logic               relu_en,
  input  logic               eng_done,
  output logic               smax_start,
  input  logic               smax_done,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_err,
  output logic               busy,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [2:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and the source holds its data
  // until the transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_SMAX  = 3'd3,
    S_HOLD  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [TMR_W-1:0]   TMO        = TMR_W'(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eng_active_d;

  // The timer holds the cycles elapsed since the last start pulse; a timeout
  // fires on the edge that would bring it to TIMEOUT_CYC without a done.
  assign timer_inc = timer_q + TMR_W'(1);

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_START;
          layer_d = '0;
          timer_d = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        timer_d = timer_inc;
      end
      S_WAIT: begin
        if (eng_done) begin
          timer_d = '0;
          if (layer_q == LAST_LAYER) begin
            state_d = S_SMAX;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = S_START;
          end
        end else if (timer_inc == TMO) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_SMAX: begin
        if (smax_done) begin
          state_d = S_HOLD;
        end else if (timer_inc == TMO) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (clr_err) begin
          state_d = S_IDLE;
          layer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign eng_active_d = (state_d == S_START) || (state_d == S_WAIT);

  // Outputs are registered from the next-state values so every output is a
  // clean flop and the layer selects stay fixed for the whole layer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      in_capture  <= 1'b0;
      eng_start   <= 1'b0;
      eng_layer   <= '0;
      eng_src_sel <= 1'b0;
      relu_en     <= 1'b0;
      smax_start  <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      in_ready    <= (state_d == S_IDLE);
      in_capture  <= (state_q == S_IDLE) && (state_d == S_START);
      eng_start   <= (state_d == S_START);
      eng_layer   <= eng_active_d ? layer_d : '0;
      eng_src_sel <= eng_active_d && (layer_d != '0);
      relu_en     <= eng_active_d && (layer_d != LAST_LAYER);
      smax_start  <= (state_q == S_WAIT) && (state_d == S_SMAX);
      out_valid   <= (state_d == S_HOLD);
      busy        <= (state_d != S_IDLE);
      timeout_err <= (state_d == S_ERR);
    end
  end

  assign frame_cnt = cnt_q;
  assign state_dbg = state_q;

endmodule
